riscv_soc_test_ctrl: RTL and testbench

Synthesizable SoC test controller; the parametrised successor to the fixed-delay simulation harness around riscv + inst_mem + data_mem.
- Sequences the CPU core reset.
- Snoops the core's instruction and data buses.
- Detects a pass/fail signature store to a configurable "tohost" address.
- Enforces a cycle timeout and a PC-hang watchdog.
- Reports verdict, cycle count and store count on registered outputs, usable in simulation or on FPGA.

---
 rtl/riscv_soc_test_ctrl_if.sv | 15 +
 rtl/riscv_soc_test_ctrl.sv | 116 +++++++++++
 tb/tb_riscv_soc_test_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_soc_test_ctrl_if.sv
// Core bus snoop bundle: instruction fetch and data access as seen by the test controller.
interface riscv_soc_test_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_ce;
    logic [ADDR_W-1:0] inst_addr;
    logic              data_ce;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;

    modport master (output inst_ce, inst_addr, data_ce, data_we, data_addr, data_wdata);
    modport slave  (input  inst_ce, inst_addr, data_ce, data_we, data_addr, data_wdata);
endinterface

// File: rtl/riscv_soc_test_ctrl.sv
// SoC test controller: sequences core reset, snoops the core buses and latches a
// pass/fail/timeout/hang verdict with cycle and store counts.
module riscv_soc_test_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 32,
    parameter int                RST_CYCLES  = 4,
    parameter int                TIMEOUT     = 100000,
    parameter int                HANG_CYCLES = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_0100)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    riscv_soc_test_ctrl_if.slave bus,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           status,
    output logic [DATA_W-1:0]    fail_code,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     store_cnt
);
    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4,
        S_HANG    = 3'd5
    } state_t;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int HC_W = $clog2(HANG_CYCLES);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
    // Trip when this repeat brings the count up to HANG_CYCLES-1.
    localparam logic [HC_W-1:0]  HC_TRIP = HC_W'(HANG_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            term;
    logic [RC_W-1:0]   rst_cnt;
    logic [HC_W-1:0]   hang_cnt;
    logic [ADDR_W-1:0] prev_addr;
    logic              store, sig, repeat_fetch;

    assign status       = state;
    assign store        = bus.data_ce & bus.data_we;
    assign sig          = store && (bus.data_addr == TOHOST_ADDR) && (bus.data_wdata != '0);
    assign repeat_fetch = bus.inst_ce && (bus.inst_addr == prev_addr);

    // Verdict for this RUN edge; S_RUN means keep running.
    always_comb begin
        term = S_RUN;
        if (sig)
            term = (bus.data_wdata == DATA_W'(1)) ? S_PASS : S_FAIL;
        else if (repeat_fetch && hang_cnt == HC_TRIP)
            term = S_HANG;
        else if (cycle_cnt == TO_LAST)
            term = S_TIMEOUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            cycle_cnt <= '0;
            store_cnt <= '0;
            rst_cnt   <= '0;
            hang_cnt  <= '0;
            prev_addr <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_cnt == RC_LAST) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (store) store_cnt <= store_cnt + 1'b1;
                    if (bus.inst_ce) prev_addr <= bus.inst_addr;
                    hang_cnt <= repeat_fetch ? hang_cnt + 1'b1 : '0;
                    if (term != S_RUN) begin
                        state   <= term;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                        pass    <= (term == S_PASS);
                        if (term == S_FAIL) fail_code <= bus.data_wdata >> 1;
                    end
                end
                default: begin
                    // Terminal: everything frozen until a re-run is requested.
                    if (start) begin
                        state     <= S_RESET;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_code <= '0;
                        cycle_cnt <= '0;
                        store_cnt <= '0;
                        rst_cnt   <= '0;
                        hang_cnt  <= '0;
                        prev_addr <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_soc_test_ctrl.sv
// Bench for riscv_soc_test_ctrl: expected verdicts queued per scenario, compared when done rises.
module tb_riscv_soc_test_ctrl;
    logic        clk = 1'b0;
    logic        rst, start;
    logic        cpu_rst, done, pass;
    logic [2:0]  status;
    logic [31:0] fail_code, cycle_cnt, store_cnt;

    int n_chk = 0, n_err = 0, n_verdict = 0;

    typedef struct {
        logic [2:0]  status;
        logic        pass;
        logic [31:0] fail_code;
        logic [31:0] cycle_cnt;
        logic [31:0] store_cnt;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic done_q = 1'b0;

    riscv_soc_test_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    riscv_soc_test_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(32), .RST_CYCLES(4),
        .TIMEOUT(50), .HANG_CYCLES(8), .TOHOST_ADDR(32'h0000_0100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .cpu_rst(cpu_rst), .done(done), .pass(pass), .status(status),
        .fail_code(fail_code), .cycle_cnt(cycle_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Verdict monitor: pop one expectation per rising edge of done.
    always @(negedge clk) begin
        if (done && !done_q) begin
            n_verdict++;
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("v_status",    {29'b0, status}, {29'b0, e.status});
                chk("v_pass",      {31'b0, pass},   {31'b0, e.pass});
                chk("v_fail_code", fail_code,       e.fail_code);
                chk("v_cycle_cnt", cycle_cnt,       e.cycle_cnt);
                chk("v_store_cnt", store_cnt,       e.store_cnt);
            end
        end
        done_q <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_ce    = 1'b0;
        bus.inst_addr  = '0;
        bus.data_ce    = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_ce    = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
    endtask

    task automatic push(input logic [2:0] s, input logic p, input logic [31:0] fc,
                        input logic [31:0] cc, input logic [31:0] sc);
        exp_t x;
        x.status = s; x.pass = p; x.fail_code = fc; x.cycle_cnt = cc; x.store_cnt = sc;
        sb.push_back(x);
    endtask

    task automatic restart();
        idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rerun_status", {29'b0, status}, 32'd0);
        chk("rerun_done",   {31'b0, done},   32'd0);
        chk("rerun_cycle",  cycle_cnt,       32'd0);
        chk("rerun_store",  store_cnt,       32'd0);
        repeat (4) tick();
        chk("rerun_run",    {29'b0, status}, 32'd1);
        chk("rerun_cpurst", {31'b0, cpu_rst}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        idle();
        repeat (3) tick();
        chk("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("rst_status",  {29'b0, status},  32'd0);
        chk("rst_done",    {31'b0, done},    32'd0);
        chk("rst_pass",    {31'b0, pass},    32'd0);
        chk("rst_cycle",   cycle_cnt,        32'd0);
        chk("rst_store",   store_cnt,        32'd0);
        chk("rst_fcode",   fail_code,        32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_cpu_rst", {31'b0, cpu_rst}, (i < 4) ? 32'd1 : 32'd0);
            chk("seq_status",  {29'b0, status},  (i < 4) ? 32'd0 : 32'd1);
        end
        chk("run0_cycle", cycle_cnt, 32'd0);

        // PASS at RUN cycle 20 after five ordinary stores.
        push(3'd2, 1'b1, 32'd0, 32'd21, 32'd6);
        for (int k = 0; k <= 20; k++) begin
            idle();
            if (k inside {2, 4, 6, 8, 10}) st(32'h40, 32'(k));
            if (k == 20) st(32'h100, 32'h1);
            tick();
        end
        chk("pass_done",    {31'b0, done},    32'd1);
        chk("pass_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            st((k == 1) ? 32'h100 : 32'h40, 32'h7);
            tick();
        end
        idle();
        chk("frozen_store",  store_cnt,       32'd6);
        chk("frozen_cycle",  cycle_cnt,       32'd21);
        chk("frozen_status", {29'b0, status}, 32'd2);
        restart();

        // Zero to tohost is just a store; then FAIL with code 7>>1.
        push(3'd3, 1'b0, 32'd3, 32'd4, 32'd2);
        for (int k = 0; k <= 3; k++) begin
            idle();
            if (k == 1) st(32'h100, 32'h0);
            if (k == 3) st(32'h100, 32'h7);
            if (k == 3) begin
                chk("zero_sig_status", {29'b0, status}, 32'd1);
                chk("zero_sig_store",  store_cnt,       32'd1);
            end
            tick();
        end
        chk("fail_done", {31'b0, done}, 32'd1);
        restart();

        // TIMEOUT with a moving fetch address.
        push(3'd4, 1'b0, 32'd0, 32'd50, 32'd0);
        for (int k = 0; k < 50; k++) begin
            idle();
            bus.inst_ce = 1'b1;
            bus.inst_addr = 32'h1000 + 32'(k) * 4;
            tick();
        end
        chk("to_done", {31'b0, done}, 32'd1);
        restart();

        // Signature on the timeout edge wins.
        push(3'd2, 1'b1, 32'd0, 32'd50, 32'd1);
        for (int k = 0; k < 50; k++) begin
            idle();
            bus.inst_ce = 1'b1;
            bus.inst_addr = 32'h1000 + 32'(k) * 4;
            if (k == 49) st(32'h100, 32'h1);
            tick();
        end
        chk("to_sig_done", {31'b0, done}, 32'd1);
        restart();

        // HANG: stuck fetch, one idle fetch cycle at k=4 restarts the count.
        push(3'd5, 1'b0, 32'd0, 32'd12, 32'd0);
        for (int k = 0; k < 12; k++) begin
            idle();
            bus.inst_ce = (k != 4);
            bus.inst_addr = 32'h200;
            tick();
        end
        chk("hang_done", {31'b0, done}, 32'd1);
        restart();

        // Async reset mid-RUN.
        for (int k = 0; k < 30; k++) begin
            idle();
            if (k == 5) st(32'h40, 32'h5);
            tick();
        end
        idle();
        chk("pre_rst_cycle", cycle_cnt, 32'd30);
        chk("pre_rst_store", store_cnt, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("async_status",  {29'b0, status},  32'd0);
        chk("async_cycle",   cycle_cnt,        32'd0);
        chk("async_store",   store_cnt,        32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rerel_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        tick();
        chk("rerel_status",  {29'b0, status},  32'd1);
        chk("rerel_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        repeat (2) tick();

        chk("verdicts", 32'(n_verdict), 32'd5);
        chk("sb_left",  32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
